// File: rtl/debug_pkg.sv
// Shared constants for the host debug loader: command/reply bytes and the
// controller state encoding.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_HALT  = 8'h48;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_RESET = 8'h58;

  localparam logic [7:0] RPL_OK     = 8'h4B;
  localparam logic [7:0] RPL_ERROR  = 8'h45;
  localparam logic [7:0] RPL_HALTED = 8'h44;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_CNT0  = 3'd1,
    LD_CNT1  = 3'd2,
    LD_DATA  = 3'd3,
    LD_WRITE = 3'd4,
    RUN      = 3'd5,
    STEP     = 3'd6,
    ACK      = 3'd7
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects bytes MSB first into a SIZE-bit word; word_done flags the byte
// that completes the word.
module word_assembler #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            word_done,
  output logic [SIZE-1:0] word
);

  localparam int BYTES  = SIZE / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST = BCNT_W'(BYTES - 1);

  logic [BCNT_W-1:0] byte_cnt;
  logic [SIZE-1:0]   next_word;

  if (SIZE == 8) begin : g_single
    assign next_word = byte_data;
  end else begin : g_multi
    assign next_word = {word[SIZE-9:0], byte_data};
  end

  assign word_done = byte_valid && (byte_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (byte_valid) begin
      word     <= next_word;
      byte_cnt <= (byte_cnt == LAST) ? '0 : byte_cnt + BCNT_W'(1);
    end
  end

endmodule

// File: rtl/debug_loader.sv
// Host command decoder in front of the mips core: loads instruction memory,
// gates the core stall for run/halt/step, pulses core reset, replies one byte.
module debug_loader
  import debug_pkg::*;
#(
  parameter int SIZE        = 32,
  parameter int IMEM_ADDR_W = 10,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  input  logic                   i_halt,
  input  logic                   i_tx_ready,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [SIZE-1:0]        o_imem_wdata,
  output logic                   o_stall,
  output logic                   o_cpu_rst
);

  state_t state_q, state_d;

  logic [7:0]       reply_q, reply_d;
  logic             reply_load;
  logic [7:0]       count_lo_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] count_full;
  logic             count_lo_load, count_load;
  logic             word_cnt_clr, word_cnt_inc;
  logic             cpu_pulse_q, cpu_pulse_d;

  logic             asm_valid, asm_clr, word_done;
  logic [SIZE-1:0]  asm_word;

  assign count_full = CNT_W'({i_rx_data, count_lo_q});

  word_assembler #(.SIZE(SIZE)) u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .byte_valid (asm_valid),
    .byte_data  (i_rx_data),
    .word_done  (word_done),
    .word       (asm_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    reply_d       = reply_q;
    reply_load    = 1'b0;
    count_lo_load = 1'b0;
    count_load    = 1'b0;
    word_cnt_clr  = 1'b0;
    word_cnt_inc  = 1'b0;
    cpu_pulse_d   = 1'b0;
    asm_valid     = 1'b0;
    asm_clr       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: state_d = LD_CNT0;
            CMD_RUN:  state_d = RUN;
            CMD_STEP: begin
              // A halted core cannot step; report it without unstalling.
              if (i_halt) begin
                state_d    = ACK;
                reply_d    = RPL_HALTED;
                reply_load = 1'b1;
              end else begin
                state_d = STEP;
              end
            end
            CMD_RESET: begin
              cpu_pulse_d = 1'b1;
              state_d     = ACK;
              reply_d     = RPL_OK;
              reply_load  = 1'b1;
            end
            CMD_HALT: begin
              state_d    = ACK;
              reply_d    = RPL_OK;
              reply_load = 1'b1;
            end
            default: begin
              state_d    = ACK;
              reply_d    = RPL_ERROR;
              reply_load = 1'b1;
            end
          endcase
        end
      end

      LD_CNT0: begin
        if (i_rx_valid) begin
          count_lo_load = 1'b1;
          state_d       = LD_CNT1;
        end
      end

      LD_CNT1: begin
        if (i_rx_valid) begin
          count_load = 1'b1;
          if (count_full == '0) begin
            state_d    = ACK;
            reply_d    = RPL_OK;
            reply_load = 1'b1;
          end else begin
            word_cnt_clr = 1'b1;
            asm_clr      = 1'b1;
            state_d      = LD_DATA;
          end
        end
      end

      LD_DATA: begin
        asm_valid = i_rx_valid;
        if (word_done) state_d = LD_WRITE;
      end

      LD_WRITE: begin
        word_cnt_inc = 1'b1;
        if (word_cnt_q + CNT_W'(1) == count_q) begin
          state_d    = ACK;
          reply_d    = RPL_OK;
          reply_load = 1'b1;
        end else begin
          state_d = LD_DATA;
        end
      end

      RUN: begin
        // A core halt outranks a host halt arriving in the same cycle.
        if (i_halt) begin
          state_d    = ACK;
          reply_d    = RPL_HALTED;
          reply_load = 1'b1;
        end else if (i_rx_valid && (i_rx_data == CMD_HALT)) begin
          state_d    = ACK;
          reply_d    = RPL_OK;
          reply_load = 1'b1;
        end
      end

      STEP: begin
        state_d    = ACK;
        reply_d    = RPL_OK;
        reply_load = 1'b1;
      end

      ACK: begin
        if (i_tx_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reply_q     <= '0;
      count_lo_q  <= '0;
      count_q     <= '0;
      word_cnt_q  <= '0;
      cpu_pulse_q <= 1'b0;
    end else begin
      if (reply_load)    reply_q    <= reply_d;
      if (count_lo_load) count_lo_q <= i_rx_data;
      if (count_load)    count_q    <= count_full;
      if (word_cnt_clr)      word_cnt_q <= '0;
      else if (word_cnt_inc) word_cnt_q <= word_cnt_q + CNT_W'(1);
      cpu_pulse_q <= cpu_pulse_d;
    end
  end

  // The core is held in reset for the whole load so it restarts at PC 0.
  assign o_cpu_rst    = cpu_pulse_q || (state_q == LD_CNT0) || (state_q == LD_CNT1) ||
                        (state_q == LD_DATA) || (state_q == LD_WRITE);
  assign o_stall      = !((state_q == RUN) || (state_q == STEP));
  assign o_imem_we    = (state_q == LD_WRITE);
  assign o_imem_addr  = word_cnt_q[IMEM_ADDR_W-1:0];
  assign o_imem_wdata = asm_word;
  assign o_tx_valid   = (state_q == ACK);
  assign o_tx_data    = reply_q;

endmodule

// File: tb/tb_debug_loader.sv
// Directed self-checking bench for debug_loader: load, run/halt, step,
// error/reset commands and reset in the middle of a load or run.
module tb_debug_loader;

  localparam int SIZE        = 32;
  localparam int IMEM_ADDR_W = 10;
  localparam int CNT_W       = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [7:0]             i_rx_data = '0;
  logic                   i_rx_valid = 1'b0;
  logic                   i_halt = 1'b0;
  logic                   i_tx_ready = 1'b0;
  logic [7:0]             o_tx_data;
  logic                   o_tx_valid;
  logic                   o_imem_we;
  logic [IMEM_ADDR_W-1:0] o_imem_addr;
  logic [SIZE-1:0]        o_imem_wdata;
  logic                   o_stall;
  logic                   o_cpu_rst;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [IMEM_ADDR_W-1:0] wr_addr[$];
  logic [SIZE-1:0]        wr_data[$];
  logic                   mon_load = 1'b0;
  int                     rst_low_cnt = 0;
  int                     stall_low_cnt = 0;
  int                     cpu_rst_hi_cnt = 0;
  logic [7:0]             seq[$];

  always #5 clk = ~clk;

  debug_loader #(
    .SIZE        (SIZE),
    .IMEM_ADDR_W (IMEM_ADDR_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_halt       (i_halt),
    .i_tx_ready   (i_tx_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_stall      (o_stall),
    .o_cpu_rst    (o_cpu_rst)
  );

  // Observe writes and stall/reset activity on the falling edge.
  always @(negedge clk) begin
    if (o_imem_we) begin
      wr_addr.push_back(o_imem_addr);
      wr_data.push_back(o_imem_wdata);
    end
    if (mon_load && !o_cpu_rst) rst_low_cnt++;
    if (!o_stall) stall_low_cnt++;
    if (o_cpu_rst) cpu_rst_hi_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic applySequence();
    foreach (seq[i]) applyStimulus(seq[i]);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " stall"},    64'(o_stall),      64'd1);
    checkOutput({tag, " cpu_rst"},  64'(o_cpu_rst),    64'd0);
    checkOutput({tag, " we"},       64'(o_imem_we),    64'd0);
    checkOutput({tag, " addr"},     64'(o_imem_addr),  64'd0);
    checkOutput({tag, " wdata"},    64'(o_imem_wdata), 64'd0);
    checkOutput({tag, " tx_valid"}, 64'(o_tx_valid),   64'd0);
    checkOutput({tag, " tx_data"},  64'(o_tx_data),    64'd0);
  endtask

  // Waits (bounded) for a reply, holds i_tx_ready low for 'hold' cycles, then accepts it.
  task automatic checkReply(input string tag, input logic [7:0] expected, input int hold);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (o_tx_valid) seen = 1'b1;
    end
    checkOutput({tag, " tx_valid seen"}, 64'(seen), 64'd1);
    checkOutput({tag, " tx_data"}, 64'(o_tx_data), 64'(expected));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, " tx_valid held"}, 64'(o_tx_valid), 64'd1);
      checkOutput({tag, " tx_data stable"}, 64'(o_tx_data), 64'(expected));
    end
    @(posedge clk); #1;
    i_tx_ready = 1'b1;
    @(posedge clk); #1;
    i_tx_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, " tx_valid dropped"}, 64'(o_tx_valid), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    $display("[TB] starting debug_loader directed test");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-word load
    wr_addr.delete(); wr_data.delete();
    applyStimulus(8'h4C);
    rst_low_cnt = 0;
    mon_load    = 1'b1;
    seq = '{8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
    applySequence();
    @(posedge clk); #1;
    mon_load = 1'b0;
    checkOutput("load2 write count", 64'(wr_addr.size()), 64'd2);
    checkOutput("load2 addr0", 64'(wr_addr[0]), 64'd0);
    checkOutput("load2 data0", 64'(wr_data[0]), 64'h20080005);
    checkOutput("load2 addr1", 64'(wr_addr[1]), 64'd1);
    checkOutput("load2 data1", 64'(wr_data[1]), 64'hAC010004);
    checkOutput("load2 cpu_rst low cycles", 64'(rst_low_cnt), 64'd0);
    checkReply("load2", 8'h4B, 0);

    // Zero-count load
    wr_addr.delete(); wr_data.delete();
    seq = '{8'h4C, 8'h00, 8'h00};
    applySequence();
    checkReply("load0", 8'h4B, 0);
    checkOutput("load0 write count", 64'(wr_addr.size()), 64'd0);

    // Run, then host halt
    applyStimulus(8'h52);
    @(negedge clk);
    checkOutput("run stall after R", 64'(o_stall), 64'd0);
    repeat (3) @(posedge clk);
    applyStimulus(8'h47);
    @(negedge clk);
    checkOutput("run ignores other byte", 64'(o_stall), 64'd0);
    applyStimulus(8'h48);
    @(negedge clk);
    checkOutput("run stall after H", 64'(o_stall), 64'd1);
    checkReply("run-H", 8'h4B, 0);

    // Run, then core halt at cycle 20
    applyStimulus(8'h52);
    repeat (18) @(posedge clk);
    @(negedge clk);
    checkOutput("run20 stall before halt", 64'(o_stall), 64'd0);
    @(posedge clk); #1;
    i_halt = 1'b1;
    @(posedge clk); #1;
    i_halt = 1'b0;
    @(negedge clk);
    checkOutput("run20 stall after halt", 64'(o_stall), 64'd1);
    checkReply("run-halt", 8'h44, 0);

    // Core halt and host H together: halted reply wins
    applyStimulus(8'h52);
    @(posedge clk); #1;
    i_rx_data  = 8'h48;
    i_rx_valid = 1'b1;
    i_halt     = 1'b1;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
    i_halt     = 1'b0;
    checkReply("run-both", 8'h44, 0);

    // Single step with a slow transmitter
    @(posedge clk); #1;
    stall_low_cnt = 0;
    applyStimulus(8'h53);
    checkReply("step", 8'h4B, 5);
    checkOutput("step unstalled cycles", 64'(stall_low_cnt), 64'd1);

    // Step while halted: no unstall
    @(posedge clk); #1;
    i_halt        = 1'b1;
    stall_low_cnt = 0;
    applyStimulus(8'h53);
    checkReply("step-halted", 8'h44, 0);
    checkOutput("step-halted unstalled cycles", 64'(stall_low_cnt), 64'd0);
    i_halt = 1'b0;

    // Unknown command and core reset
    applyStimulus(8'h7A);
    checkReply("error", 8'h45, 0);
    @(posedge clk); #1;
    cpu_rst_hi_cnt = 0;
    applyStimulus(8'h58);
    checkReply("cpu-reset", 8'h4B, 0);
    checkOutput("cpu-reset pulse cycles", 64'(cpu_rst_hi_cnt), 64'd1);

    // Reset after 2 of 4 data bytes
    wr_addr.delete(); wr_data.delete();
    seq = '{8'h4C, 8'h01, 8'h00, 8'hAA, 8'hBB};
    applySequence();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("midload");
    repeat (3) @(posedge clk);
    checkOutput("midload write count", 64'(wr_addr.size()), 64'd0);
    seq = '{8'h4C, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    applySequence();
    checkReply("reload", 8'h4B, 0);
    checkOutput("reload write count", 64'(wr_addr.size()), 64'd1);
    checkOutput("reload addr", 64'(wr_addr[0]), 64'd0);
    checkOutput("reload data", 64'(wr_data[0]), 64'h11223344);

    // Reset during run and during a pending reply
    applyStimulus(8'h52);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("midrun");
    applyStimulus(8'h7A);
    @(negedge clk);
    checkOutput("pending reply valid", 64'(o_tx_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("midack");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
